serial_adder: RTL and testbench

- Bit-serial N-bit adder: one bit per clock, through a full-adder cell built from two half-adder stages plus a carry flip-flop.
- Sits directly downstream of the half-adder primitive. It consumes S/AS-style sum and carry pairs and turns them into a multi-bit sequential result.
- Uses a start/done handshake.
- Replaces a wide ripple adder where area matters more than latency.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/serial_adder_fa_bit.sv | 25 ++
 rtl/serial_adder.sv | 102 ++++++++++
 tb/tb_serial_adder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Width of the bit counter for a WIDTH-bit operation
   function automatic int cnt_w(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_adder_fa_bit.sv
// Combinational full-adder cell: two half-adder stages plus the carry OR.
module half_adder (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   assign s = x ^ y;
   assign c = x & y;
endmodule

module fa_bit (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);
   logic s1, c1, c2;

   half_adder u_ha0 (.x(x),  .y(y),  .s(s1), .c(c1));
   half_adder u_ha1 (.x(s1), .y(ci), .s(s),  .c(c2));

   assign co = c1 | c2;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder with start/done handshake, one bit per clock.
// Define SERIAL_ADDER_OVERFLOW_EN to build the signed-overflow flag register.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int CW = cnt_w(WIDTH);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr;
   logic             carry;
   logic [CW-1:0]    count;
   logic             fa_s, fa_co;
   logic             accept, last;

   fa_bit u_fa (.x(a_sr[0]), .y(b_sr[0]), .ci(carry), .s(fa_s), .co(fa_co));

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last      = 1'b0;
      case (state)
         ST_IDLE: if (start) begin
            accept    = 1'b1;
            state_nxt = ST_SHIFT;
         end
         ST_SHIFT: if (count == CW'(WIDTH-1)) begin
            last      = 1'b1;
            state_nxt = ST_DONE;
         end
         ST_DONE: begin
            accept    = start;
            state_nxt = start ? ST_SHIFT : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   assign busy = (state == ST_SHIFT);
   assign done = (state == ST_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         carry  <= 1'b0;
         count  <= '0;
         sum    <= '0;
         cout   <= 1'b0;
      end else if (accept) begin
         a_sr  <= a;
         b_sr  <= b;
         carry <= cin;
         count <= '0;
      end else if (state == ST_SHIFT) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         res_sr <= {fa_s, res_sr[WIDTH-1:1]};
         carry  <= fa_co;
         count  <= count + 1'b1;
         // Outputs only move on the final bit so sum stays stable through SHIFT
         if (last) begin
            sum  <= {fa_s, res_sr[WIDTH-1:1]};
            cout <= fa_co;
         end
      end
   end

`ifdef SERIAL_ADDER_OVERFLOW_EN
   logic ovf_q;

   // On the last bit, carry holds the carry into the MSB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    ovf_q <= 1'b0;
      else if (last) ovf_q <= carry ^ fa_co;
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8).
module tb_serial_adder;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         cin = 1'b0;
   logic         busy, done, cout, ovf;
   logic [W-1:0] sum;

   int checks = 0;
   int errors = 0;

`ifdef SERIAL_ADDER_OVERFLOW_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   serial_adder #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
      a = va; b = vb; cin = vc; start = 1'b1;
      step();
      start = 1'b0;
      a = $urandom_range(255, 0);
      b = $urandom_range(255, 0);
      cin = $urandom_range(1, 0);
   endtask

   // Called just after the accepting edge; leaves the bench in the done cycle
   task automatic expect_result(input string tag, input logic [W-1:0] held,
                                input logic [W-1:0] es, input logic ec, input logic eo,
                                input int inject_at);
      for (int i = 0; i < W; i++) begin
         chk({tag, " busy"}, {31'd0, busy}, 32'd1);
         chk({tag, " no_done"}, {31'd0, done}, 32'd0);
         chk({tag, " sum_held"}, {24'd0, sum}, {24'd0, held});
         if (i == inject_at) begin
            start = 1'b1; a = 8'hFF; b = 8'hFF;
            step();
            start = 1'b0;
         end else begin
            step();
         end
      end
      chk({tag, " done"}, {31'd0, done}, 32'd1);
      chk({tag, " busy_low"}, {31'd0, busy}, 32'd0);
      chk({tag, " sum"}, {24'd0, sum}, {24'd0, es});
      chk({tag, " cout"}, {31'd0, cout}, {31'd0, ec});
      chk({tag, " ovf"}, {31'd0, ovf}, {31'd0, eo});
   endtask

   task automatic finish_idle(input string tag, input logic [W-1:0] es, input logic ec);
      step();
      chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
      chk({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, " sum_kept"}, {24'd0, sum}, {24'd0, es});
      chk({tag, " cout_kept"}, {31'd0, cout}, {31'd0, ec});
   endtask

   initial begin
      #2;
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst done", {31'd0, done}, 32'd0);
      chk("rst sum", {24'd0, sum}, 32'd0);
      chk("rst cout", {31'd0, cout}, 32'd0);
      chk("rst ovf", {31'd0, ovf}, 32'd0);
      step(); step();
      #3 rst_n = 1'b1;
      step();

      launch(8'h00, 8'h00, 1'b0);
      expect_result("zero", 8'h00, 8'h00, 1'b0, 1'b0, -1);
      finish_idle("zero", 8'h00, 1'b0);

      launch(8'hFF, 8'h01, 1'b0);
      expect_result("ff+01", 8'h00, 8'h00, 1'b1, 1'b0, -1);
      finish_idle("ff+01", 8'h00, 1'b1);

      launch(8'h7F, 8'h01, 1'b0);
      expect_result("7f+01", 8'h00, 8'h80, 1'b0, OVF_ON, -1);
      finish_idle("7f+01", 8'h80, 1'b0);

      launch(8'h80, 8'h80, 1'b0);
      expect_result("80+80", 8'h80, 8'h00, 1'b1, OVF_ON, -1);
      finish_idle("80+80", 8'h00, 1'b1);

      // Back-to-back: second start raised during the done cycle
      launch(8'hA5, 8'h5A, 1'b1);
      expect_result("a5+5a+1", 8'h00, 8'h00, 1'b1, 1'b0, -1);
      launch(8'h03, 8'h04, 1'b0);
      expect_result("b2b 03+04", 8'h00, 8'h07, 1'b0, 1'b0, -1);
      finish_idle("b2b", 8'h07, 1'b0);

      // Start pulse during SHIFT must be ignored
      launch(8'h10, 8'h20, 1'b0);
      expect_result("ignore", 8'h07, 8'h30, 1'b0, 1'b0, 2);
      finish_idle("ignore", 8'h30, 1'b0);

      // Reset in the middle of SHIFT
      launch(8'h55, 8'h22, 1'b0);
      step(); step(); step();
      chk("pre_rst busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst busy", {31'd0, busy}, 32'd0);
      chk("mid_rst done", {31'd0, done}, 32'd0);
      chk("mid_rst sum", {24'd0, sum}, 32'd0);
      chk("mid_rst cout", {31'd0, cout}, 32'd0);
      chk("mid_rst ovf", {31'd0, ovf}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_hold done", {31'd0, done}, 32'd0);
      end
      #3 rst_n = 1'b1;
      for (int i = 0; i < W + 2; i++) begin
         step();
         chk("post_rst no_done", {31'd0, done}, 32'd0);
         chk("post_rst idle", {31'd0, busy}, 32'd0);
      end

      launch(8'h0F, 8'h01, 1'b0);
      expect_result("0f+01", 8'h00, 8'h10, 1'b0, 1'b0, -1);
      finish_idle("0f+01", 8'h10, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
